// File: rtl/csi_rx_deskew_ctrl_pkg.sv
// Shared constants and types for the CSI-2 receive lane deskew calibration block.
package csi_rx_deskew_ctrl_pkg;

    localparam int unsigned NUM_LANE = 2;
    localparam int unsigned TAP_W    = 5;
    localparam int unsigned LANE_W   = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
    localparam int unsigned NUM_TAP  = 1 << TAP_W;
    localparam int unsigned LEN_W    = TAP_W + 1;

    localparam logic [NUM_LANE*TAP_W-1:0] DSKEW_DEFAULT_TAPS = 10'h063;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_MEAS,
        ST_EVAL,
        ST_APPLY,
        ST_DONE
    } dskew_state_e;

endpackage

// File: rtl/csi_rx_deskew_ctrl_if.sv
// Control/status bundle between the deskew controller and the lane PHY/aligner logic.
interface csi_rx_deskew_ctrl_if;
    import csi_rx_deskew_ctrl_pkg::*;

    logic                      start;
    logic [NUM_LANE-1:0]       sync_hit;
    logic [NUM_LANE*TAP_W-1:0] delay;
    logic [NUM_LANE-1:0]       delay_ld;
    logic                      busy;
    logic                      done;
    logic [NUM_LANE-1:0]       lane_err;

    modport master (
        output start, sync_hit,
        input  delay, delay_ld, busy, done, lane_err
    );

    modport slave (
        input  start, sync_hit,
        output delay, delay_ld, busy, done, lane_err
    );

endinterface

// File: rtl/csi_rx_eye_tracker.sv
// Tracks the current passing-tap run and the longest run seen, and derives the eye centre.
module csi_rx_eye_tracker
    import csi_rx_deskew_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_eval,
    input  logic             i_pass,
    input  logic             i_last,
    input  logic [TAP_W-1:0] i_tap,
    output logic [LEN_W-1:0] o_best_len,
    output logic [TAP_W-1:0] o_centre_c
);

    logic [TAP_W-1:0] r_run_start;
    logic [LEN_W-1:0] r_run_len;
    logic [TAP_W-1:0] r_best_start;
    logic [LEN_W-1:0] r_best_len;

    logic [TAP_W-1:0] w_run_start_nxt;
    logic [LEN_W-1:0] w_run_len_nxt;
    logic [LEN_W-1:0] w_cand_len;
    logic             w_take;
    logic [LEN_W-1:0] w_len_m1;
    logic [LEN_W-1:0] w_sum;

    // A run is a candidate when it closes on a failing tap or is still open at the last tap
    always_comb begin
        w_run_len_nxt   = i_pass ? (r_run_len + LEN_W'(1)) : '0;
        w_run_start_nxt = (i_pass && (r_run_len == '0)) ? i_tap : r_run_start;
        w_cand_len      = i_pass ? w_run_len_nxt : r_run_len;
        w_take          = (!i_pass || i_last) && (w_cand_len > r_best_len);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_clear) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_eval) begin
            r_run_start <= w_run_start_nxt;
            r_run_len   <= w_run_len_nxt;
            if (w_take) begin
                r_best_start <= w_run_start_nxt;
                r_best_len   <= w_cand_len;
            end
        end
    end

    // Centre in TAP_W+1 bits; start + (len-1)/2 stays inside the run, so it fits TAP_W
    always_comb begin
        w_len_m1   = (r_best_len == '0) ? '0 : (r_best_len - LEN_W'(1));
        w_sum      = LEN_W'(r_best_start) + (w_len_m1 >> 1);
        o_centre_c = TAP_W'(w_sum);
    end

    assign o_best_len = r_best_len;

endmodule

// File: rtl/csi_rx_deskew_ctrl.sv
// Per-lane IDELAY tap calibration sequencer: sweeps every tap per lane, counts sync hits,
// and programs the centre of the widest passing eye (or the fallback tap).
module csi_rx_deskew_ctrl
    import csi_rx_deskew_ctrl_pkg::*;
#(
    parameter int unsigned               SETTLE_CYC   = 16,
    parameter int unsigned               WINDOW_CYC   = 65536,
    parameter int unsigned               MIN_HITS     = 4,
    parameter int unsigned               MIN_EYE      = 3,
    parameter logic [NUM_LANE*TAP_W-1:0] DEFAULT_TAPS = DSKEW_DEFAULT_TAPS
)(
    input  logic                 clock,
    input  logic                 reset_n,
    csi_rx_deskew_ctrl_if.slave  bus
);

    localparam int unsigned CNT_MAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned HIT_W   = $clog2(MIN_HITS + 1);

    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(NUM_TAP - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANE - 1);

    dskew_state_e              r_state,    w_state_nxt;
    logic [LANE_W-1:0]         r_lane,     w_lane_nxt;
    logic [TAP_W-1:0]          r_tap,      w_tap_nxt;
    logic [CNT_W-1:0]          r_cnt,      w_cnt_nxt;
    logic [HIT_W-1:0]          r_hits,     w_hits_nxt;
    logic [NUM_LANE*TAP_W-1:0] r_delay,    w_delay_nxt;
    logic [NUM_LANE-1:0]       r_delay_ld, w_delay_ld_nxt;
    logic                      r_busy,     w_busy_nxt;
    logic                      r_done,     w_done_nxt;
    logic [NUM_LANE-1:0]       r_lane_err, w_lane_err_nxt;

    logic                      w_trk_clear;
    logic                      w_trk_eval;
    logic                      w_pass;
    logic                      w_last;
    logic [LEN_W-1:0]          w_best_len;
    logic [TAP_W-1:0]          w_centre;
    logic                      w_eye_ok;
    logic [TAP_W-1:0]          w_final;

    assign w_pass   = (r_hits == HIT_W'(MIN_HITS));
    assign w_last   = (r_tap == TAP_LAST);
    assign w_eye_ok = (w_best_len >= LEN_W'(MIN_EYE));
    assign w_final  = w_eye_ok ? w_centre : DEFAULT_TAPS[r_lane*TAP_W +: TAP_W];

    csi_rx_eye_tracker u_eye (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clear    (w_trk_clear),
        .i_eval     (w_trk_eval),
        .i_pass     (w_pass),
        .i_last     (w_last),
        .i_tap      (r_tap),
        .o_best_len (w_best_len),
        .o_centre_c (w_centre)
    );

    // Next-state and registered-output logic; start restarts from any state
    always_comb begin
        w_state_nxt    = r_state;
        w_lane_nxt     = r_lane;
        w_tap_nxt      = r_tap;
        w_cnt_nxt      = r_cnt;
        w_hits_nxt     = r_hits;
        w_delay_nxt    = r_delay;
        w_delay_ld_nxt = '0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_lane_err_nxt = r_lane_err;
        w_trk_clear    = 1'b0;
        w_trk_eval     = 1'b0;

        if (bus.start) begin
            w_state_nxt    = ST_LOAD;
            w_lane_nxt     = '0;
            w_tap_nxt      = '0;
            w_cnt_nxt      = '0;
            w_hits_nxt     = '0;
            w_busy_nxt     = 1'b1;
            w_done_nxt     = 1'b0;
            w_lane_err_nxt = '0;
            w_trk_clear    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_LOAD: begin
                    w_delay_nxt[r_lane*TAP_W +: TAP_W] = r_tap;
                    w_delay_ld_nxt[r_lane]             = 1'b1;
                    w_cnt_nxt                          = '0;
                    w_hits_nxt                         = '0;
                    w_state_nxt                        = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_MEAS;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_MEAS: begin
                    if (bus.sync_hit[r_lane] && !w_pass)
                        w_hits_nxt = r_hits + HIT_W'(1);
                    if (r_cnt == CNT_W'(WINDOW_CYC - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_EVAL;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    w_trk_eval = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_APPLY;
                    end else begin
                        w_tap_nxt   = r_tap + TAP_W'(1);
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_APPLY: begin
                    w_delay_nxt[r_lane*TAP_W +: TAP_W] = w_final;
                    w_delay_ld_nxt[r_lane]             = 1'b1;
                    if (!w_eye_ok)
                        w_lane_err_nxt[r_lane] = 1'b1;
                    if (r_lane == LANE_LAST) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_lane_nxt  = r_lane + LANE_W'(1);
                        w_tap_nxt   = '0;
                        w_trk_clear = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_lane     <= '0;
            r_tap      <= '0;
            r_cnt      <= '0;
            r_hits     <= '0;
            r_delay    <= DEFAULT_TAPS;
            r_delay_ld <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lane_err <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane     <= w_lane_nxt;
            r_tap      <= w_tap_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hits     <= w_hits_nxt;
            r_delay    <= w_delay_nxt;
            r_delay_ld <= w_delay_ld_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_lane_err <= w_lane_err_nxt;
        end
    end

    assign bus.delay    = r_delay;
    assign bus.delay_ld = r_delay_ld;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.lane_err = r_lane_err;

endmodule

// File: tb/tb_csi_rx_deskew_ctrl.sv
// Bench for csi_rx_deskew_ctrl: a lane PHY model emits sync hits according to per-lane
// pass masks and the applied tap; final taps are compared with a run-scan reference.
module tb_csi_rx_deskew_ctrl;
    import csi_rx_deskew_ctrl_pkg::*;

    localparam int unsigned SETTLE   = 4;
    localparam int unsigned WINDOW   = 64;
    localparam int unsigned LANE_CYC = NUM_TAP * (1 + SETTLE + WINDOW + 1) + 1;
    localparam int unsigned CAL_CYC  = NUM_LANE * LANE_CYC;
    localparam int unsigned LD_CAL   = NUM_LANE * (NUM_TAP + 1);
    localparam logic [4:0]  DEF_TAP  = 5'h03;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    csi_rx_deskew_ctrl_if dif ();

    csi_rx_deskew_ctrl #(
        .SETTLE_CYC   (SETTLE),
        .WINDOW_CYC   (WINDOW),
        .MIN_HITS     (4),
        .MIN_EYE      (3),
        .DEFAULT_TAPS (10'h063)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (dif)
    );

    int total = 0;
    int bad   = 0;
    int ld_count    = 0;
    int busy_cycles = 0;

    logic [31:0] pass_mask [NUM_LANE];
    logic [4:0]  cur_tap   [NUM_LANE];
    int          period    [NUM_LANE];
    int          phase     [NUM_LANE];
    int          budget    [NUM_LANE];

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] range_mask(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    // Reference: longest run of passing taps (earliest on ties), centre or fallback
    function automatic logic [5:0] ref_cal(input logic [31:0] mask);
        int best_len = 0, best_start = 0, cur_len = 0, cur_start = 0;
        for (int t = 0; t < 32; t++) begin
            if (mask[t]) begin
                if (cur_len == 0) cur_start = t;
                cur_len++;
                if (cur_len > best_len) begin
                    best_len   = cur_len;
                    best_start = cur_start;
                end
            end else begin
                cur_len = 0;
            end
        end
        if (best_len >= 3) return {1'b0, 5'(best_start + (best_len - 1) / 2)};
        return {1'b1, DEF_TAP};
    endfunction

    function automatic logic [31:0] rand_mask();
        logic [31:0] m = '0;
        int n = $urandom_range(0, 3);
        for (int r = 0; r < n; r++) begin
            int lo = $urandom_range(0, 31);
            int hi = lo + $urandom_range(0, 10);
            if (hi > 31) hi = 31;
            m = m | range_mask(lo, hi);
        end
        return m;
    endfunction

    // Lane PHY model and per-cycle monitor
    initial begin
        dif.sync_hit = '0;
        for (int l = 0; l < NUM_LANE; l++) begin
            cur_tap[l] = DEF_TAP;
            period[l]  = 4;
            phase[l]   = 0;
            budget[l]  = 0;
        end
        forever begin
            @(negedge clock);
            if (reset_n) begin
                total++;
                assert ($countones(dif.delay_ld) <= 1) else begin
                    bad++;
                    $error("FAIL ld_onehot: observed=%b expected=at most one bit", dif.delay_ld);
                end
            end
            if (dif.busy === 1'b1) busy_cycles++;
            for (int l = 0; l < NUM_LANE; l++) begin
                if (dif.delay_ld[l] === 1'b1) begin
                    ld_count++;
                    cur_tap[l] = dif.delay[l*TAP_W +: TAP_W];
                    phase[l]   = 0;
                    period[l]  = $urandom_range(2, 12);
                    budget[l]  = $urandom_range(0, 3);
                end
            end
            for (int l = 0; l < NUM_LANE; l++) begin
                logic hit;
                hit = 1'b0;
                if (pass_mask[l][cur_tap[l]]) begin
                    hit = ((phase[l] % period[l]) == 0);
                end else if (budget[l] > 0 && $urandom_range(0, 15) == 0) begin
                    hit = 1'b1;
                    budget[l]--;
                end
                phase[l]++;
                dif.sync_hit[l] = hit;
            end
        end
    end

    task automatic pulse_start();
        dif.start   = 1'b1;
        busy_cycles = 0;
        ld_count    = 0;
        tick();
        dif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (dif.done !== 1'b1 && n < CAL_CYC + 100) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(dif.done), 32'd1);
        tick();
    endtask

    task automatic check_result(input string tag, input logic [5:0] e0, input logic [5:0] e1);
        chk({tag, "_d0"},   32'(dif.delay[0 +: TAP_W]),     32'(e0[4:0]));
        chk({tag, "_d1"},   32'(dif.delay[TAP_W +: TAP_W]), 32'(e1[4:0]));
        chk({tag, "_err"},  32'(dif.lane_err),              32'({e1[5], e0[5]}));
        chk({tag, "_busy"}, 32'(dif.busy),                  32'd0);
        chk({tag, "_nld"},  32'(ld_count),                  32'(LD_CAL));
        chk({tag, "_bcyc"}, 32'(busy_cycles),               32'(CAL_CYC));
    endtask

    task automatic run_cal(input string tag, input logic [31:0] m0, input logic [31:0] m1,
                           input logic [5:0] e0, input logic [5:0] e1);
        pass_mask[0] = m0;
        pass_mask[1] = m1;
        pulse_start();
        chk({tag, "_busy_on"}, 32'(dif.busy), 32'd1);
        chk({tag, "_done_clr"}, 32'(dif.done), 32'd0);
        wait_done(tag);
        check_result(tag, e0, e1);
    endtask

    initial begin
        logic [31:0] m0, m1;
        dif.start    = 1'b0;
        pass_mask[0] = '0;
        pass_mask[1] = '0;
        repeat (3) tick();
        chk("rst_delay", 32'(dif.delay),    32'h063);
        chk("rst_ld",    32'(dif.delay_ld), 32'd0);
        chk("rst_busy",  32'(dif.busy),     32'd0);
        chk("rst_done",  32'(dif.done),     32'd0);
        chk("rst_err",   32'(dif.lane_err), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        run_cal("t1", range_mask(10, 20), range_mask(3, 5), 6'h0F, 6'h04);
        run_cal("t2", range_mask(2, 6) | range_mask(20, 24), range_mask(3, 5), 6'h04, 6'h04);
        run_cal("t3", range_mask(10, 20), 32'h0, 6'h0F, {1'b1, DEF_TAP});
        run_cal("t4a", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h0F, 6'h0F);
        run_cal("t4b", range_mask(30, 31), range_mask(0, 2), {1'b1, DEF_TAP}, 6'h01);
        run_cal("t4c", range_mask(0, 5) | range_mask(25, 31), range_mask(0, 1) | range_mask(4, 4),
                6'h1C, {1'b1, DEF_TAP});

        // Restart mid lane 1: lane 0 tap is retained until it is recalibrated
        pass_mask[0] = range_mask(10, 20);
        pass_mask[1] = range_mask(3, 5);
        pulse_start();
        repeat (LANE_CYC + 300) tick();
        chk("t5_mid_busy", 32'(dif.busy), 32'd1);
        chk("t5_mid_done", 32'(dif.done), 32'd0);
        chk("t5_mid_d0",   32'(dif.delay[0 +: TAP_W]), 32'h0F);
        pass_mask[0] = range_mask(0, 8);
        pulse_start();
        chk("t5_rs_busy", 32'(dif.busy), 32'd1);
        chk("t5_rs_d0",   32'(dif.delay[0 +: TAP_W]), 32'h0F);
        wait_done("t5");
        check_result("t5", ref_cal(range_mask(0, 8)), ref_cal(range_mask(3, 5)));

        // Asynchronous reset in the middle of a measurement window
        pass_mask[0] = range_mask(10, 20);
        pulse_start();
        repeat (40) tick();
        chk("t6_pre_busy", 32'(dif.busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_delay", 32'(dif.delay),    32'h063);
        chk("t6_busy",  32'(dif.busy),     32'd0);
        chk("t6_done",  32'(dif.done),     32'd0);
        chk("t6_ld",    32'(dif.delay_ld), 32'd0);
        chk("t6_err",   32'(dif.lane_err), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("t6_idle_busy", 32'(dif.busy), 32'd0);

        for (int i = 0; i < 3; i++) begin
            m0 = rand_mask();
            m1 = rand_mask();
            run_cal($sformatf("rnd%0d", i), m0, m1, ref_cal(m0), ref_cal(m1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
